// File: rtl/dds_mod_pkg.sv
// Shared encodings and defaults for the modulated DDS source and its bit source.
package dds_mod_pkg;

   localparam int ACC_W_DEF = 32;
   localparam int OUT_W_DEF = 12;

   typedef enum logic [1:0] {
      MOD_NONE = 2'b00,
      MOD_ASK  = 2'b01,
      MOD_FSK  = 2'b10,
      MOD_BPSK = 2'b11
   } mod_e;

   typedef enum logic [1:0] {
      WAVE_SAW  = 2'b00,
      WAVE_TRI  = 2'b01,
      WAVE_SQR  = 2'b10,
      WAVE_SAW2 = 2'b11
   } wave_e;

   // x^5 + x^3 + 1 style feedback: new bit = lfsr[4] ^ lfsr[2], period 31
   localparam int LFSR_W     = 5;
   localparam int LFSR_TAP_A = 4;
   localparam int LFSR_TAP_B = 2;

endpackage

// File: rtl/dds_bit_src.sv
// Modulating-bit source: bit-period timer plus 5-bit LFSR, or an external bit
// latched on each strobe when MOD_EXT_BIT_EN is defined.
module dds_bit_src
   import dds_mod_pkg::*;
#(
   parameter int                BIT_PERIOD = 50000,
   parameter logic [LFSR_W-1:0] LFSR_SEED  = 5'h01
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
`ifdef MOD_EXT_BIT_EN
   input  logic ext_bit,
`endif
   output logic mod_bit,
   output logic bit_strobe
);

   localparam int              CNT_W    = $clog2(BIT_PERIOD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);

   logic [CNT_W-1:0] cnt;

   assign bit_strobe = en && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= bit_strobe ? '0 : cnt + CNT_W'(1);
      end
   end

`ifdef MOD_EXT_BIT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mod_bit <= 1'b0;
      end else if (bit_strobe) begin
         mod_bit <= ext_bit;
      end
   end
`else
   // a zero seed would lock the LFSR, so it is replaced by 1
   localparam logic [LFSR_W-1:0] SEED = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

   logic [LFSR_W-1:0] lfsr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= SEED;
      end else if (bit_strobe) begin
         lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B]};
      end
   end

   assign mod_bit = lfsr[LFSR_W-1];
`endif

endmodule

// File: rtl/dds_mod_gen.sv
// Fast-clock DDS with ASK/FSK/BPSK on saw/triangle/square waveforms.
// Define MOD_EXT_BIT_EN to take the modulating bit from the ext_bit port.
module dds_mod_gen
   import dds_mod_pkg::*;
#(
   parameter int          ACC_W      = ACC_W_DEF,
   parameter int          OUT_W      = OUT_W_DEF,
   parameter int          BIT_PERIOD = 50000,
   parameter logic [4:0]  LFSR_SEED  = 5'h01
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mod_sel,
   input  logic [1:0]       wave_sel,
   input  logic [ACC_W-1:0] tw0,
   input  logic [ACC_W-1:0] tw1,
`ifdef MOD_EXT_BIT_EN
   input  logic             ext_bit,
`endif
   output logic [OUT_W-1:0] phase_out,
   output logic [OUT_W-1:0] sample_out,
   output logic             mod_bit,
   output logic             bit_strobe
);

   localparam logic [OUT_W-1:0] HALF_TURN = {1'b1, {(OUT_W-1){1'b0}}};

   logic [ACC_W-1:0] acc_p0;
   logic [ACC_W-1:0] tw;
   logic [OUT_W-1:0] p;
   logic [OUT_W-1:0] pm;
   logic [OUT_W-1:0] sample;

   function automatic logic [OUT_W-1:0] shape(input logic [1:0] sel, input logic [OUT_W-1:0] ph);
      logic [OUT_W-1:0] dbl;
      dbl = {ph[OUT_W-2:0], 1'b0};
      case (wave_e'(sel))
         WAVE_TRI: shape = ph[OUT_W-1] ? ~dbl : dbl;
         WAVE_SQR: shape = {OUT_W{ph[OUT_W-1]}};
         default:  shape = ph;
      endcase
   endfunction

   dds_bit_src #(
      .BIT_PERIOD (BIT_PERIOD),
      .LFSR_SEED  (LFSR_SEED)
   ) u_bit_src (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
`ifdef MOD_EXT_BIT_EN
      .ext_bit    (ext_bit),
`endif
      .mod_bit    (mod_bit),
      .bit_strobe (bit_strobe)
   );

   always_comb begin
      tw = tw0;
      if (mod_sel == MOD_FSK && mod_bit) tw = tw1;
   end

   // stage p0: phase accumulator
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_p0 <= '0;
      end else if (en) begin
         acc_p0 <= acc_p0 + tw;
      end
   end

   assign p  = acc_p0[ACC_W-1 -: OUT_W];
   assign pm = (mod_sel == MOD_BPSK && mod_bit) ? p + HALF_TURN : p;

   always_comb begin
      sample = shape(wave_sel, pm);
      if (mod_sel == MOD_ASK && !mod_bit) sample = '0;
   end

   // stage p1: registered phase and sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_out  <= '0;
         sample_out <= '0;
      end else if (en) begin
         phase_out  <= pm;
         sample_out <= sample;
      end
   end

endmodule

// File: tb/tb_dds_mod_gen.sv
// Randomized and directed bench for dds_mod_gen against a cycle-level arithmetic model.
module tb_dds_mod_gen;

   localparam int BP = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [1:0]  mod_sel;
   logic [1:0]  wave_sel;
   logic [31:0] tw0;
   logic [31:0] tw1;
   logic [11:0] phase_out;
   logic [11:0] sample_out;
   logic        mod_bit;
   logic        bit_strobe;
`ifdef MOD_EXT_BIT_EN
   logic        ext_bit = 1'b1;
`endif

   always #5 clk = ~clk;

   dds_mod_gen #(
      .ACC_W      (32),
      .OUT_W      (12),
      .BIT_PERIOD (BP),
      .LFSR_SEED  (5'h01)
   ) dut (
`ifdef MOD_EXT_BIT_EN
      .ext_bit    (ext_bit),
`endif
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .mod_sel    (mod_sel),
      .wave_sel   (wave_sel),
      .tw0        (tw0),
      .tw1        (tw1),
      .phase_out  (phase_out),
      .sample_out (sample_out),
      .mod_bit    (mod_bit),
      .bit_strobe (bit_strobe)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
   endtask

   // reference model: bit sequence after k strobes, plus plain-arithmetic DDS state
   bit          mb_seq[31];
   logic [31:0] m_acc;
   int          m_cyc;
   int          m_ns;
   int          m_phase;
   int          m_sample;

   function automatic bit m_mb();
`ifdef MOD_EXT_BIT_EN
      return (m_ns > 0);
`else
      return mb_seq[m_ns % 31];
`endif
   endfunction

   task automatic model_reset();
      m_acc = 0; m_cyc = 0; m_ns = 0; m_phase = 0; m_sample = 0;
   endtask

   task automatic model_edge();
      bit mb;
      int pm, d, w;
      if (en !== 1'b1) return;
      mb = m_mb();
      pm = (int'(m_acc >> 20) + ((mod_sel == 2'd3 && mb) ? 2048 : 0)) % 4096;
      d  = (pm * 2) % 4096;
      case (wave_sel)
         2'd1:    w = (pm >= 2048) ? 4095 - d : d;
         2'd2:    w = (pm >= 2048) ? 4095 : 0;
         default: w = pm;
      endcase
      if (mod_sel == 2'd1 && !mb) w = 0;
      m_phase  = pm;
      m_sample = w;
      m_acc    = m_acc + ((mod_sel == 2'd2 && mb) ? tw1 : tw0);
      m_cyc++;
      if (m_cyc % BP == 0) m_ns++;
   endtask

   // entered at a falling edge with inputs already driven; returns at the next falling edge
   task automatic tick();
      bit es;
      #1;
      es = (en === 1'b1) && (m_cyc % BP == BP - 1);
      check_eq("strobe", 32'(bit_strobe), 32'(es));
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_eq("phase", 32'(phase_out), 32'(m_phase));
      check_eq("sample", 32'(sample_out), 32'(m_sample));
      check_eq("mod_bit", 32'(mod_bit), 32'(m_mb()));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      model_reset();
      check_eq("rst_phase", 32'(phase_out), 32'd0);
      check_eq("rst_sample", 32'(sample_out), 32'd0);
      check_eq("rst_strobe", 32'(bit_strobe), 32'd0);
      check_eq("rst_mod_bit", 32'(mod_bit), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int s;
      bit mbh[0:200];
      bit mb_prev;
      int strobes, d;
      logic [11:0] prev_ph, snap_ph, snap_smp;
      logic        snap_mb;

      s = 1;
      for (int k = 0; k < 31; k++) begin
         mb_seq[k] = ((s >> 4) & 1) != 0;
         s = ((s << 1) & 31) | (((s >> 4) ^ (s >> 2)) & 1);
      end
      model_reset();
      rst_n = 1'b0; en = 1'b0; mod_sel = 2'd0; wave_sel = 2'd0; tw0 = '0; tw1 = '0;

      // saw ramp and wrap
      do_reset();
      en = 1'b1; mod_sel = 2'd0; wave_sel = 2'd0; tw0 = 32'h0010_0000; tw1 = '0;
      tick();
      check_eq("saw_first", 32'(sample_out), 32'd0);
      for (int k = 1; k <= 4097; k++) begin
         tick();
         if (k <= 3 || k >= 4095) check_eq("saw_ramp", 32'(sample_out), 32'(k % 4096));
      end

      // triangle then square at quarter points
      for (int ws = 1; ws <= 2; ws++) begin
         do_reset();
         en = 1'b1; mod_sel = 2'd0; wave_sel = ws[1:0]; tw0 = 32'h0400_0000;
         for (int n = 1; n <= 64; n++) begin
            tick();
            if (n == 17) check_eq(ws == 1 ? "tri_at_400" : "sqr_at_400", 32'(sample_out),
                                  ws == 1 ? 32'h800 : 32'h000);
            if (n == 49) check_eq(ws == 1 ? "tri_at_c00" : "sqr_at_c00", 32'(sample_out),
                                  ws == 1 ? 32'h7FF : 32'hFFF);
         end
      end

      // bit timer and LFSR
      do_reset();
      en = 1'b1; mod_sel = 2'd0; wave_sel = 2'd0; tw0 = 32'h0010_0000;
      strobes = 0;
      for (int n = 1; n <= 40; n++) begin
         #1;
         if (bit_strobe) strobes++;
         tick();
`ifdef MOD_EXT_BIT_EN
         if (n == 3) check_eq("ext_bit_pre", 32'(mod_bit), 32'd0);
         if (n == 4) check_eq("ext_bit_first", 32'(mod_bit), 32'd1);
`else
         if (n == 15) check_eq("lfsr_bit_pre", 32'(mod_bit), 32'd0);
         if (n == 16) check_eq("lfsr_bit_first1", 32'(mod_bit), 32'd1);
`endif
      end
      check_eq("strobe_count", 32'(strobes), 32'd10);

      // FSK: phase step doubles while the bit is 1
      do_reset();
      en = 1'b1; mod_sel = 2'd2; wave_sel = 2'd0; tw0 = 32'h0010_0000; tw1 = 32'h0020_0000;
      mbh[0] = mod_bit;
      prev_ph = phase_out;
      for (int n = 1; n <= 120; n++) begin
         tick();
         mbh[n] = mod_bit;
         if (n >= 2) begin
            d = (int'(phase_out) - int'(prev_ph) + 4096) % 4096;
            check_eq("fsk_step", 32'(d), mbh[n-2] ? 32'd2 : 32'd1);
         end
         prev_ph = phase_out;
      end

      // BPSK: half-turn offset while the bit is 1
      do_reset();
      en = 1'b1; mod_sel = 2'd3; wave_sel = 2'd0; tw0 = 32'h0010_0000;
      for (int n = 1; n <= 60; n++) begin
         mb_prev = mod_bit;
         tick();
         check_eq("bpsk_phase", 32'(phase_out), 32'((n - 1 + (mb_prev ? 2048 : 0)) % 4096));
      end

      // ASK: zero output while the bit is 0
      do_reset();
      en = 1'b1; mod_sel = 2'd1; wave_sel = 2'd0; tw0 = 32'h0010_0000;
      for (int n = 1; n <= 60; n++) begin
         mb_prev = mod_bit;
         tick();
         if (!mb_prev) check_eq("ask_zero", 32'(sample_out), 32'd0);
      end

      // en low for 10 cycles, starting where a strobe would otherwise fire
      mod_sel = 2'd0;
      for (int n = 0; n < BP && (m_cyc % BP != BP - 1); n++) tick();
      en = 1'b0;
      snap_ph = phase_out; snap_smp = sample_out; snap_mb = mod_bit;
      for (int n = 0; n < 10; n++) begin
         tick();
         check_eq("hold_phase", 32'(phase_out), 32'(snap_ph));
         check_eq("hold_sample", 32'(sample_out), 32'(snap_smp));
         check_eq("hold_mod_bit", 32'(mod_bit), 32'(snap_mb));
      end
      en = 1'b1;
      for (int n = 0; n < 12; n++) tick();

      // randomized run
      do_reset();
      en = 1'b1; tw0 = $urandom; tw1 = $urandom;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 15) == 0) begin
            mod_sel  = 2'($urandom_range(0, 3));
            wave_sel = 2'($urandom_range(0, 3));
         end
         if ($urandom_range(0, 63) == 0) begin
            tw0 = $urandom;
            tw1 = $urandom;
         end
         en = ($urandom_range(0, 7) != 0);
         tick();
      end

      // asynchronous reset in the middle of a cycle
      en = 1'b1; mod_sel = 2'd0; wave_sel = 2'd0; tw0 = 32'h0010_0000;
      for (int n = 0; n < 20; n++) tick();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_phase", 32'(phase_out), 32'd0);
      check_eq("async_rst_sample", 32'(sample_out), 32'd0);
      check_eq("async_rst_strobe", 32'(bit_strobe), 32'd0);
      check_eq("async_rst_mod_bit", 32'(mod_bit), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 8; n++) tick();
      check_eq("post_rst_ramp", 32'(sample_out), 32'd7);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
